multiplexador_display: RTL and testbench

MULTIPLEXADOR_DISPLAY -- requirements
Module: multiplexador_display

---
 rtl/multiplexador_display_if.sv | 26 ++
 rtl/multiplexador_display.sv | 133 +++++++++++++
 tb/tb_multiplexador_display.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/multiplexador_display_if.sv
`default_nettype none
// ============================================================================
// Module      : multiplexador_display_if
// Description : Valid/ready handshake carrying the digit codes to the display.
// Revision    : 1.0 - initial release
// ============================================================================
interface multiplexador_display_if #(
    parameter int N_DIGITOS = 4
);
    logic [4*N_DIGITOS-1:0] dados;
    logic                   ent_valido;
    logic                   ent_pronto;

    modport master (
        output dados,
        output ent_valido,
        input  ent_pronto
    );

    modport slave (
        input  dados,
        input  ent_valido,
        output ent_pronto
    );
endinterface
`default_nettype wire

// File: rtl/multiplexador_display.sv
`default_nettype none
// ============================================================================
// Module      : multiplexador_display
// Description : Multiplexed 7-segment driver with double-buffered digit codes.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplexador_display #(
    parameter int N_DIGITOS = 4,
    parameter int DIV_SCAN  = 1000
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    multiplexador_display_if.slave    bus,
    input  wire logic                 en,
    input  wire logic                 modo_hex,
    input  wire logic                 supressao,
    output logic [N_DIGITOS-1:0]      an,
    output logic [6:0]                seg
);

    localparam int                   c_IDX_W    = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam logic [c_IDX_W-1:0]   c_LAST_IDX = c_IDX_W'(N_DIGITOS - 1);
    localparam logic [15:0]          c_PRE_TC   = 16'(DIV_SCAN - 1);
    localparam logic [N_DIGITOS-1:0] c_AN_ONE   = N_DIGITOS'(1);

    logic [15:0]            r_presc;
    logic [c_IDX_W-1:0]     r_idx;
    logic [4*N_DIGITOS-1:0] r_shadow;
    logic [4*N_DIGITOS-1:0] r_disp;
    logic                   r_full;
    logic [N_DIGITOS-1:0]   r_an;
    logic [6:0]             r_seg;

    logic                   w_tc;
    logic                   w_frame_end;
    logic                   w_capture;
    logic [3:0]             w_dig [N_DIGITOS];
    logic [N_DIGITOS-1:0]   w_zero_hi;
    logic                   w_supp;
    logic [6:0]             w_code;

    function automatic logic [6:0] f_seg(input logic [3:0] nib, input logic hex);
        logic [6:0] v_code;
        v_code = 7'h00;
        case (nib)
            4'h0: v_code = 7'h3F;
            4'h1: v_code = 7'h06;
            4'h2: v_code = 7'h5B;
            4'h3: v_code = 7'h4F;
            4'h4: v_code = 7'h66;
            4'h5: v_code = 7'h6D;
            4'h6: v_code = 7'h7D;
            4'h7: v_code = 7'h07;
            4'h8: v_code = 7'h7F;
            4'h9: v_code = 7'h6F;
            4'hA: v_code = hex ? 7'h77 : 7'h00;
            4'hB: v_code = hex ? 7'h7C : 7'h00;
            4'hC: v_code = hex ? 7'h39 : 7'h00;
            4'hD: v_code = hex ? 7'h5E : 7'h00;
            4'hE: v_code = hex ? 7'h79 : 7'h00;
            4'hF: v_code = hex ? 7'h71 : 7'h00;
            default: v_code = 7'h00;
        endcase
        return v_code;
    endfunction

    assign w_tc           = (r_presc == c_PRE_TC);
    assign w_frame_end    = w_tc && (r_idx == c_LAST_IDX);
    assign w_capture      = bus.ent_valido && !r_full;
    assign bus.ent_pronto = !r_full;

    genvar k;
    generate
        for (k = 0; k < N_DIGITOS; k++) begin : g_dig
            assign w_dig[k] = r_disp[4*k +: 4];
        end
    endgenerate

    // w_zero_hi[k] is set when digit k and every digit above it are zero.
    always_comb begin
        logic v_run;
        v_run     = 1'b1;
        w_zero_hi = '0;
        for (int i = N_DIGITOS - 1; i >= 0; i--) begin
            v_run        = v_run && (w_dig[i] == 4'h0);
            w_zero_hi[i] = v_run;
        end
    end

    assign w_supp = supressao && (r_idx != '0) && w_zero_hi[r_idx];
    assign w_code = f_seg(w_dig[r_idx], modo_hex);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_presc  <= '0;
            r_idx    <= '0;
            r_shadow <= '0;
            r_disp   <= '0;
            r_full   <= 1'b0;
            r_an     <= '0;
            r_seg    <= '0;
        end else begin
            r_presc <= w_tc ? 16'd0 : r_presc + 16'd1;

            if (w_tc) begin
                r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
            end

            // Capture needs the flag clear and transfer needs it set, so a
            // capture on a frame-end cycle waits for the following frame end.
            if (w_capture) begin
                r_shadow <= bus.dados;
                r_full   <= 1'b1;
            end else if (w_frame_end && r_full) begin
                r_disp <= r_shadow;
                r_full <= 1'b0;
            end

            if (en) begin
                r_an  <= c_AN_ONE << r_idx;
                r_seg <= w_supp ? 7'h00 : w_code;
            end else begin
                r_an  <= '0;
                r_seg <= 7'h00;
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_multiplexador_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplexador_display
// Description : Directed self-checking bench, N_DIGITOS=4 and DIV_SCAN=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplexador_display;

    logic       clock;
    logic       reset;
    logic       en;
    logic       modo_hex;
    logic       supressao;
    logic [3:0] an;
    logic [6:0] seg;

    int total;
    int bad;
    int n;   // clock edges since the last reset release

    multiplexador_display_if #(.N_DIGITOS(4)) bus ();

    multiplexador_display #(
        .N_DIGITOS (4),
        .DIV_SCAN  (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .en        (en),
        .modo_hex  (modo_hex),
        .supressao (supressao),
        .an        (an),
        .seg       (seg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        n = n + 1;
        #1;
    endtask

    // Captures a value and runs to the frame end that transfers it.
    task automatic load_value(input logic [15:0] v);
        bus.dados      = v;
        bus.ent_valido = 1'b1;
        tick();
        bus.ent_valido = 1'b0;
        while (n % 16 != 0) tick();
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        en             = 1'b1;
        modo_hex       = 1'b0;
        supressao      = 1'b0;
        bus.ent_valido = 1'b0;
        bus.dados      = 16'h0000;
        n              = 0;
        tick();
        tick();
        total++; if (bus.ent_pronto !== 1'b1) begin bad++; $display("FAIL rst_pronto got=%b want=1", bus.ent_pronto); end
        total++; if (an !== 4'b0000) begin bad++; $display("FAIL rst_an got=%b want=0000", an); end
        total++; if (seg !== 7'h00) begin bad++; $display("FAIL rst_seg got=%h want=00", seg); end
        reset = 1'b0;
        n     = 0;
        for (int i = 1; i <= 16; i++) begin
            int d;
            tick();
            d = ((n - 1) / 4) % 4;
            total++; if (an !== (4'b0001 << d)) begin bad++; $display("FAIL rst_scan_an n=%0d got=%b want=%b", n, an, 4'b0001 << d); end
            total++; if (seg !== 7'h3F) begin bad++; $display("FAIL rst_scan_seg n=%0d got=%h want=3f", n, seg); end
        end
    endtask

    task automatic test_bcd_capture();
        logic [6:0] exp_seg [0:3];
        exp_seg = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        bus.dados      = 16'h1234;
        bus.ent_valido = 1'b1;
        tick();
        bus.ent_valido = 1'b0;
        total++; if (bus.ent_pronto !== 1'b0) begin bad++; $display("FAIL cap_pronto got=%b want=0", bus.ent_pronto); end
        bus.dados      = 16'h9999;
        bus.ent_valido = 1'b1;
        tick();
        bus.ent_valido = 1'b0;
        total++; if (bus.ent_pronto !== 1'b0) begin bad++; $display("FAIL cap_busy_pronto got=%b want=0", bus.ent_pronto); end
        while (n % 16 != 15) tick();
        total++; if (bus.ent_pronto !== 1'b0) begin bad++; $display("FAIL cap_pre_fe_pronto got=%b want=0", bus.ent_pronto); end
        tick();
        total++; if (bus.ent_pronto !== 1'b1) begin bad++; $display("FAIL cap_post_fe_pronto got=%b want=1", bus.ent_pronto); end
        for (int i = 1; i <= 16; i++) begin
            int d;
            tick();
            d = ((n - 1) / 4) % 4;
            total++; if (an !== (4'b0001 << d)) begin bad++; $display("FAIL bcd_an n=%0d got=%b want=%b", n, an, 4'b0001 << d); end
            total++; if (seg !== exp_seg[d]) begin bad++; $display("FAIL bcd_seg n=%0d got=%h want=%h", n, seg, exp_seg[d]); end
        end
    endtask

    task automatic test_hex();
        logic [6:0] exp_seg [0:3];
        exp_seg  = '{7'h5E, 7'h39, 7'h7C, 7'h77};
        modo_hex = 1'b1;
        load_value(16'hABCD);
        for (int i = 1; i <= 16; i++) begin
            int d;
            tick();
            d = ((n - 1) / 4) % 4;
            total++; if (an !== (4'b0001 << d)) begin bad++; $display("FAIL hex_an n=%0d got=%b want=%b", n, an, 4'b0001 << d); end
            total++; if (seg !== exp_seg[d]) begin bad++; $display("FAIL hex_seg n=%0d got=%h want=%h", n, seg, exp_seg[d]); end
        end
        modo_hex = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            int d;
            tick();
            d = ((n - 1) / 4) % 4;
            total++; if (an !== (4'b0001 << d)) begin bad++; $display("FAIL bcdhex_an n=%0d got=%b want=%b", n, an, 4'b0001 << d); end
            total++; if (seg !== 7'h00) begin bad++; $display("FAIL bcdhex_seg n=%0d got=%h want=00", n, seg); end
        end
    endtask

    task automatic test_suppression();
        logic [15:0] vals [0:2];
        logic [6:0]  exp_seg [0:2][0:3];
        vals    = '{16'h0007, 16'h0000, 16'h0107};
        exp_seg = '{'{7'h07, 7'h00, 7'h00, 7'h00},
                    '{7'h3F, 7'h00, 7'h00, 7'h00},
                    '{7'h07, 7'h3F, 7'h06, 7'h00}};
        supressao = 1'b1;
        for (int v = 0; v < 3; v++) begin
            load_value(vals[v]);
            for (int i = 1; i <= 16; i++) begin
                int d;
                tick();
                d = ((n - 1) / 4) % 4;
                total++; if (an !== (4'b0001 << d)) begin bad++; $display("FAIL supp_an v=%h n=%0d got=%b want=%b", vals[v], n, an, 4'b0001 << d); end
                total++; if (seg !== exp_seg[v][d]) begin bad++; $display("FAIL supp_seg v=%h n=%0d got=%h want=%h", vals[v], n, seg, exp_seg[v][d]); end
            end
        end
        supressao = 1'b0;
    endtask

    task automatic test_enable();
        en             = 1'b0;
        bus.dados      = 16'h2222;
        bus.ent_valido = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            bus.ent_valido = 1'b0;
            if (i == 1) begin
                total++; if (bus.ent_pronto !== 1'b0) begin bad++; $display("FAIL en_cap_pronto got=%b want=0", bus.ent_pronto); end
            end
            total++; if (an !== 4'b0000) begin bad++; $display("FAIL en_off_an n=%0d got=%b want=0000", n, an); end
            total++; if (seg !== 7'h00) begin bad++; $display("FAIL en_off_seg n=%0d got=%h want=00", n, seg); end
        end
        en = 1'b1;
        tick();
        total++; if (an !== 4'b0100) begin bad++; $display("FAIL en_resume_an got=%b want=0100", an); end
        total++; if (seg !== 7'h06) begin bad++; $display("FAIL en_resume_seg got=%h want=06", seg); end
        while (n % 16 != 0) tick();
        for (int i = 1; i <= 16; i++) begin
            int d;
            tick();
            d = ((n - 1) / 4) % 4;
            total++; if (an !== (4'b0001 << d)) begin bad++; $display("FAIL en_frame_an n=%0d got=%b want=%b", n, an, 4'b0001 << d); end
            total++; if (seg !== 7'h5B) begin bad++; $display("FAIL en_frame_seg n=%0d got=%h want=5b", n, seg); end
        end
    endtask

    task automatic test_reset_midframe();
        bus.dados      = 16'h5678;
        bus.ent_valido = 1'b1;
        tick();
        bus.ent_valido = 1'b0;
        tick();
        reset          = 1'b1;
        bus.ent_valido = 1'b1;
        tick();
        total++; if (bus.ent_pronto !== 1'b1) begin bad++; $display("FAIL mid_rst_pronto got=%b want=1", bus.ent_pronto); end
        total++; if (an !== 4'b0000) begin bad++; $display("FAIL mid_rst_an got=%b want=0000", an); end
        total++; if (seg !== 7'h00) begin bad++; $display("FAIL mid_rst_seg got=%h want=00", seg); end
        reset          = 1'b0;
        bus.ent_valido = 1'b0;
        n              = 0;
        for (int i = 1; i <= 32; i++) begin
            int d;
            tick();
            d = ((n - 1) / 4) % 4;
            total++; if (bus.ent_pronto !== 1'b1) begin bad++; $display("FAIL mid_pronto n=%0d got=%b want=1", n, bus.ent_pronto); end
            total++; if (an !== (4'b0001 << d)) begin bad++; $display("FAIL mid_an n=%0d got=%b want=%b", n, an, 4'b0001 << d); end
            total++; if (seg !== 7'h3F) begin bad++; $display("FAIL mid_seg n=%0d got=%h want=3f", n, seg); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_bcd_capture();
        test_hex();
        test_suppression();
        test_enable();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
